// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, register-select width
// and the memory-stage state encoding.
package riscv_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_SEL_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage : riscv_pkg

// File: rtl/mem_watchdog.sv
// Access watchdog: counts cycles while a memory access is outstanding and
// flags expiry on the TIMEOUT-th cycle. Only instantiated under MEM_TIMEOUT_EN.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    output logic o_expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Count restarts from zero every time the stage leaves the access state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_active) begin
            r_count <= '0;
        end else if (!o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_active & (r_count == CW'(TIMEOUT - 1));

endmodule : mem_watchdog

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream while they
// are outstanding, resolves branches and retires into write-back.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int WORD_SIZE = riscv_pkg::WORD_SIZE,
    parameter int ADDR_SIZE = 10,
    parameter int TIMEOUT   = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ex_valid,
    input  logic [WORD_SIZE-1:0]            alu_result,
    input  logic [WORD_SIZE-1:0]            rdata2,
    input  logic [WORD_SIZE-1:0]            branch_target,
    input  logic [riscv_pkg::REG_SEL_W-1:0] rd,
    input  logic                            en_write_reg,
    input  logic                            alu_zero,
    input  logic                            alu_pos,
    input  logic                            branch,
    input  logic                            mem_read,
    input  logic                            mem_write,
    input  logic                            write_source,
    output logic                            dmem_req,
    output logic                            dmem_we,
    output logic [ADDR_SIZE-1:0]            dmem_addr,
    output logic [WORD_SIZE-1:0]            dmem_wdata,
    input  logic                            dmem_ack,
    input  logic [WORD_SIZE-1:0]            dmem_rdata,
    output logic                            stall,
    output logic                            pc_src,
    output logic [WORD_SIZE-1:0]            pc_target,
    output logic                            wb_valid,
    output logic [riscv_pkg::REG_SEL_W-1:0] wb_rd,
    output logic                            wb_en_write_reg,
    output logic [WORD_SIZE-1:0]            wb_data,
    output logic                            mem_err
);

    import riscv_pkg::*;

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic                 w_is_mem;
    logic                 w_accept;
    logic                 w_retire_alu;
    logic                 w_ack_done;
    logic                 w_abort;
    logic                 w_unused;

    logic [ADDR_SIZE-1:0] r_addr;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [REG_SEL_W-1:0] r_rd;
    logic                 r_en;
    logic                 r_wsrc;
    logic [WORD_SIZE-1:0] r_alu;

    logic                 r_wb_valid;
    logic [REG_SEL_W-1:0] r_wb_rd;
    logic                 r_wb_en;
    logic [WORD_SIZE-1:0] r_wb_data;

    // alu_pos is reserved for future BLT/BGE support.
    assign w_unused = alu_pos ^ TIMEOUT[0];

    assign w_is_mem     = ex_valid & (mem_read | mem_write);
    assign w_accept     = (r_state == IDLE) & w_is_mem;
    assign w_retire_alu = (r_state == IDLE) & ex_valid & ~(mem_read | mem_write);
    assign w_ack_done   = (r_state == ACCESS) & dmem_ack;

`ifdef MEM_TIMEOUT_EN
    logic w_expired;
    logic r_mem_err;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_active  (r_state == ACCESS),
        .o_expired (w_expired)
    );

    assign w_abort = (r_state == ACCESS) & ~dmem_ack & w_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else if (w_abort) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_abort = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        dmem_req     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = ACCESS;
                    stall        = 1'b1;
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                if (dmem_ack || w_abort) begin
                    w_next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request fields are captured once at accept so they stay stable while
    // the memory is busy, regardless of what upstream presents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_en    <= 1'b0;
            r_wsrc  <= 1'b0;
            r_alu   <= '0;
        end else if (w_accept) begin
            r_addr  <= alu_result[ADDR_SIZE+1:2];
            r_we    <= mem_write;
            r_wdata <= rdata2;
            r_rd    <= rd;
            r_en    <= en_write_reg;
            r_wsrc  <= write_source;
            r_alu   <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_en    <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_retire_alu | w_ack_done | w_abort;
            if (w_retire_alu) begin
                r_wb_rd   <= rd;
                r_wb_en   <= en_write_reg;
                r_wb_data <= alu_result;
            end else if (w_ack_done) begin
                r_wb_rd   <= r_rd;
                r_wb_en   <= r_en;
                r_wb_data <= r_wsrc ? dmem_rdata : r_alu;
            end else if (w_abort) begin
                r_wb_rd   <= r_rd;
                r_wb_en   <= 1'b0;
                r_wb_data <= r_alu;
            end
        end
    end

    assign dmem_we         = r_we & (r_state == ACCESS);
    assign dmem_addr       = r_addr;
    assign dmem_wdata      = r_wdata;
    assign pc_src          = ex_valid & branch & alu_zero & (r_state == IDLE);
    assign pc_target       = branch_target;
    assign wb_valid        = r_wb_valid;
    assign wb_rd           = r_wb_rd;
    assign wb_en_write_reg = r_wb_en;
    assign wb_data         = r_wb_data;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Scoreboard testbench for mem_stage; add MEM_TIMEOUT_EN to the build to
// also exercise the access timeout.
module tb_mem_stage;

    localparam int WS = 32;
    localparam int AS = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [WS-1:0] alu_result;
    logic [WS-1:0] rdata2;
    logic [WS-1:0] branch_target;
    logic [4:0]    rd;
    logic          en_write_reg, alu_zero, alu_pos, branch;
    logic          mem_read, mem_write, write_source;
    logic          dmem_req, dmem_we;
    logic [AS-1:0] dmem_addr;
    logic [WS-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [WS-1:0] dmem_rdata;
    logic          stall, pc_src;
    logic [WS-1:0] pc_target;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          wb_en_write_reg;
    logic [WS-1:0] wb_data;
    logic          mem_err;

    typedef struct packed {
        logic [4:0]    rd;
        logic          en;
        logic [WS-1:0] data;
        logic          checkData;
    } wbExp_t;

    wbExp_t expQ[$];
    int     checks   = 0;
    int     failures = 0;

    mem_stage #(
        .WORD_SIZE (WS),
        .ADDR_SIZE (AS),
        .TIMEOUT   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .alu_result      (alu_result),
        .rdata2          (rdata2),
        .branch_target   (branch_target),
        .rd              (rd),
        .en_write_reg    (en_write_reg),
        .alu_zero        (alu_zero),
        .alu_pos         (alu_pos),
        .branch          (branch),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .write_source    (write_source),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .stall           (stall),
        .pc_src          (pc_src),
        .pc_target       (pc_target),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_en_write_reg (wb_en_write_reg),
        .wb_data         (wb_data),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WS-1:0] actual,
                               input logic [WS-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        ex_valid      = 1'b0;
        alu_result    = '0;
        rdata2        = '0;
        branch_target = '0;
        rd            = '0;
        en_write_reg  = 1'b0;
        alu_zero      = 1'b0;
        alu_pos       = 1'b0;
        branch        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        write_source  = 1'b0;
        dmem_ack      = 1'b0;
        dmem_rdata    = 32'h5A5A_5A5A;
    endtask

    task automatic applyStimulus(input logic rdReq, input logic wrReq, input logic wsrc,
                                 input logic [WS-1:0] alu, input logic [WS-1:0] wdata,
                                 input logic [4:0] rdIn, input logic en,
                                 input logic br, input logic zero, input logic [WS-1:0] target);
        ex_valid      = 1'b1;
        mem_read      = rdReq;
        mem_write     = wrReq;
        write_source  = wsrc;
        alu_result    = alu;
        rdata2        = wdata;
        rd            = rdIn;
        en_write_reg  = en;
        branch        = br;
        alu_zero      = zero;
        branch_target = target;
    endtask

    // Single-cycle (non-memory) instruction: retires one edge after issue.
    task automatic runAlu(input logic [WS-1:0] alu, input logic [4:0] rdIn, input logic en,
                          input logic br, input logic zero, input logic [WS-1:0] target,
                          input logic expPc);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0, alu, 32'h0, rdIn, en, br, zero, target);
        expQ.push_back('{rd: rdIn, en: en, data: alu, checkData: 1'b1});
        @(negedge clk);
        checkOutput("alu stall", stall, 0);
        checkOutput("alu pc_src", pc_src, expPc);
        checkOutput("alu pc_target", pc_target, target);
        @(posedge clk); #1;
        clearInputs();
        @(negedge clk);
        checkOutput("alu wb_valid", wb_valid, 1);
        checkOutput("alu stall after", stall, 0);
    endtask

    // Memory instruction: ack withheld for waitCycles access cycles, then given.
    task automatic runMemOp(input logic rdReq, input logic wrReq, input logic wsrc,
                            input logic [WS-1:0] alu, input logic [WS-1:0] wdata,
                            input logic [4:0] rdIn, input logic en, input int waitCycles,
                            input logic [WS-1:0] rdata, input logic [WS-1:0] expData,
                            input logic [AS-1:0] expAddr);
        int stalls;
        stalls = 0;
        @(posedge clk); #1;
        applyStimulus(rdReq, wrReq, wsrc, alu, wdata, rdIn, en, 1'b1, 1'b1, 32'h300);
        @(negedge clk);
        checkOutput("accept dmem_req", dmem_req, 0);
        checkOutput("accept pc_src", pc_src, 1);
        if (stall === 1'b1) stalls++;
        for (int k = 0; k < waitCycles; k++) begin
            @(negedge clk);
            checkOutput("access dmem_req", dmem_req, 1);
            checkOutput("access dmem_addr", dmem_addr, expAddr);
            checkOutput("access dmem_we", dmem_we, wrReq);
            checkOutput("access dmem_wdata", dmem_wdata, wdata);
            checkOutput("access pc_src", pc_src, 0);
            if (stall === 1'b1) stalls++;
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        expQ.push_back('{rd: rdIn, en: en, data: expData, checkData: 1'b1});
        @(negedge clk);
        checkOutput("ack dmem_req", dmem_req, 1);
        checkOutput("ack dmem_addr", dmem_addr, expAddr);
        checkOutput("ack dmem_we", dmem_we, wrReq);
        checkOutput("ack stall", stall, 0);
        if (stall === 1'b1) stalls++;
        checkOutput("stall cycle count", stalls, waitCycles + 1);
        @(posedge clk); #1;
        clearInputs();
        @(negedge clk);
        checkOutput("mem wb_valid", wb_valid, 1);
        checkOutput("post-ack dmem_req", dmem_req, 0);
        checkOutput("post-ack stall", stall, 0);
    endtask

    // Monitor: every retirement pulse is matched against the next expectation.
    initial begin
        wbExp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected wb_valid", wb_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wb_rd", wb_rd, e.rd);
                    checkOutput("wb_en_write_reg", wb_en_write_reg, e.en);
                    if (e.checkData) checkOutput("wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        clearInputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset dmem_req", dmem_req, 0);
        checkOutput("reset dmem_we", dmem_we, 0);
        checkOutput("reset dmem_addr", dmem_addr, 0);
        checkOutput("reset dmem_wdata", dmem_wdata, 0);
        checkOutput("reset wb_valid", wb_valid, 0);
        checkOutput("reset wb_rd", wb_rd, 0);
        checkOutput("reset wb_data", wb_data, 0);
        checkOutput("reset mem_err", mem_err, 0);
        checkOutput("reset stall", stall, 0);

        runAlu(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        runAlu(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        runAlu(32'h4, 5'd0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0);

        runMemOp(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd7, 1'b1, 3,
                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 10'h010);
        runMemOp(1'b0, 1'b1, 1'b0, 32'h8, 32'h1234, 5'd0, 1'b0, 1,
                 32'h1111_1111, 32'h8, 10'h002);
        runMemOp(1'b1, 1'b0, 1'b1, 32'h7FD, 32'h0, 5'd31, 1'b1, 0,
                 32'hCAFE_F00D, 32'hCAFE_F00D, 10'h1FF);
        runMemOp(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'hA5A5_0001, 5'd9, 1'b1, 2,
                 32'h2222_2222, 32'hFFFF_FFF4, 10'h3FD);
        runMemOp(1'b1, 1'b0, 1'b0, 32'h124, 32'h0, 5'd12, 1'b1, 1,
                 32'h3333_3333, 32'h124, 10'h049);

        // Reset in the middle of an access abandons it; a late ack is ignored.
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("pre-reset dmem_req", dmem_req, 1);
        #2;
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("mid-access reset dmem_req", dmem_req, 0);
        checkOutput("mid-access reset stall", stall, 0);
        checkOutput("mid-access reset dmem_addr", dmem_addr, 0);
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h4444_4444;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post-reset wb_valid", wb_valid, 0);
            checkOutput("post-reset dmem_req", dmem_req, 0);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int accessCycles;
            accessCycles = 0;
            @(posedge clk); #1;
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
            expQ.push_back('{rd: 5'd4, en: 1'b0, data: 32'h0, checkData: 1'b0});
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (dmem_req === 1'b1) accessCycles++;
                if (dmem_req === 1'b1 && stall === 1'b0) break;
            end
            checkOutput("timeout access cycles", accessCycles, 4);
            @(posedge clk); #1;
            clearInputs();
            @(negedge clk);
            checkOutput("timeout wb_valid", wb_valid, 1);
            checkOutput("timeout mem_err", mem_err, 1);
            checkOutput("timeout dmem_req", dmem_req, 0);
            runAlu(32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            checkOutput("mem_err sticky", mem_err, 1);
            #2 rst = 1'b0;
            #1 checkOutput("mem_err cleared by reset", mem_err, 0);
            @(posedge clk); #1 rst = 1'b1;
        end
`else
        checkOutput("mem_err tied low", mem_err, 0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule : tb_mem_stage
